// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side handshake between the UART receiver and the
// bus-side register block.
//   o_rxdata     received byte, valid while o_rxfull = 1
//   o_rxfull     holding register contains an unread byte
//   o_frame_err  byte in holding register had stop bit = 0
//   o_overrun    a byte completed while full and was discarded (sticky)
//   i_rxack      consumer acknowledge; clears holding register and flags
// Signal names are relative to the receiver (master).
interface uart_rx_if;
    logic [7:0] o_rxdata;
    logic       o_rxfull;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_rxack;

    modport master (
        output o_rxdata,
        output o_rxfull,
        output o_frame_err,
        output o_overrun,
        input  i_rxack
    );

    modport slave (
        input  o_rxdata,
        input  o_rxfull,
        input  o_frame_err,
        input  o_overrun,
        output i_rxack
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line. Oversamples the
// line with a shared enable, validates the start bit at mid-bit, samples
// every data bit and the stop bit at its centre, and commits completed
// bytes to a one-deep holding register with framing-error and overrun flags.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_rxclken  oversampling enable, one pulse per OVERSAMPLE-th of a bit
//   i_rx       asynchronous serial input
//   o_busy     receiver not in IDLE
//   rx_bus     holding register / flags / acknowledge (uart_rx_if.master)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a low line on a tick
// S_START | counting to mid start bit, rejecting glitches
// S_DATA  | sampling 8 data bits at bit centres
// S_STOP  | sampling the stop bit and committing the byte
// S_BREAK | stop bit was low; wait for the line to go high again
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rxclken,
    input  logic       i_rx,
    output logic       o_busy,
    uart_rx_if.master  rx_bus
);

    localparam int CW = $clog2(OVERSAMPLE * 10);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          full_q, full_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          commit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            full_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= i_rx;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            full_q    <= full_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        commit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rxclken && !rx_s_q) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (i_rxclken) begin
                    if (cnt_q == CNT_HALF) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d     = '0;
                            bit_idx_d = '0;
                            state_d   = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (i_rxclken) begin
                    if (cnt_q == CNT_BIT) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        cnt_d     = '0;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (i_rxclken) begin
                    if (cnt_q == CNT_BIT) begin
                        commit  = 1'b1;
                        state_d = rx_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_BREAK: begin
                // Not gated by the tick: leave as soon as the line is high.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register. An acknowledge clears first; a commit in the same
    // cycle then reloads, so ack+commit leaves the new byte, full, no overrun.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;

        if (rx_bus.i_rxack) begin
            full_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (commit) begin
            if (!full_q || rx_bus.i_rxack) begin
                data_d = shift_q;
                full_d = 1'b1;
                ferr_d = ~rx_s_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign o_busy             = (state_q != S_IDLE);
    assign rx_bus.o_rxdata    = data_q;
    assign rx_bus.o_rxfull    = full_q;
    assign rx_bus.o_frame_err = ferr_q;
    assign rx_bus.o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int OS  = 16;
    localparam int LAT = 2 + 8 + 9 * OS + 1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rxclken = 1'b1;
    logic rx      = 1'b1;
    logic busy;

    int checks   = 0;
    int failures = 0;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_rxclken (rxclken),
        .i_rx      (rx),
        .o_busy    (busy),
        .rx_bus    (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int stop_len);
        rx = 1'b0;
        cycles(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cycles(OS);
        end
        rx = stop;
        cycles(stop_len);
        rx = 1'b1;
    endtask

    task automatic wait_full(input int max, output int n);
        n = 0;
        while (bus.o_rxfull !== 1'b1 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic ack_pulse();
        bus.i_rxack = 1'b1;
        cycles(1);
        bus.i_rxack = 1'b0;
    endtask

    initial begin
        int lat;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 8'hC3, 1'b1};

        bus.i_rxack = 1'b0;
        cycles(3);
        check("reset_rxdata", bus.o_rxdata, 8'h00);
        check("reset_rxfull", bus.o_rxfull, 1'b0);
        check("reset_ferr", bus.o_frame_err, 1'b0);
        check("reset_ovr", bus.o_overrun, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycles(5);

        // Table-driven frames, one tick per clock.
        for (int v = 0; v < 6; v++) begin
            fork
                drive_frame(vecs[v].data, vecs[v].stop, OS);
                wait_full(LAT + 50, lat);
            join
            check($sformatf("vec%0d_latency", v), lat, LAT);
            check($sformatf("vec%0d_data", v), bus.o_rxdata, vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), bus.o_frame_err, vecs[v].exp_ferr);
            ack_pulse();
            check($sformatf("vec%0d_ack_clears", v), bus.o_rxfull, 1'b0);
            cycles(6);
        end

        // Short low glitch: false start.
        rx = 1'b0;
        cycles(3);
        check("glitch_busy_high", busy, 1'b1);
        cycles(1);
        rx = 1'b1;
        cycles(20);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_no_byte", bus.o_rxfull, 1'b0);

        // Stop = 0 with line held low 40 ticks: frame error, BREAK.
        fork
            drive_frame(8'h3C, 1'b0, 40);
            wait_full(LAT + 50, lat);
        join
        check("break_latency", lat, LAT);
        check("break_data", bus.o_rxdata, 8'h3C);
        check("break_ferr", bus.o_frame_err, 1'b1);
        check("break_busy_held", busy, 1'b1);
        cycles(8);
        check("break_exit_idle", busy, 1'b0);
        check("break_no_ovr", bus.o_overrun, 1'b0);
        check("break_data_kept", bus.o_rxdata, 8'h3C);
        ack_pulse();
        cycles(4);

        // Back-to-back without ack: overrun.
        fork
            begin
                drive_frame(8'h11, 1'b1, OS);
                drive_frame(8'h22, 1'b1, OS);
            end
            begin
                cycles(2 * LAT);
                check("b2b_ovr_before", bus.o_overrun, 1'b0);
            end
        join
        check("b2b_data", bus.o_rxdata, 8'h11);
        check("b2b_full", bus.o_rxfull, 1'b1);
        check("b2b_ovr", bus.o_overrun, 1'b1);
        ack_pulse();
        check("b2b_ack_full", bus.o_rxfull, 1'b0);
        check("b2b_ack_ovr", bus.o_overrun, 1'b0);
        cycles(4);

        // Ack coincident with the second commit.
        fork
            begin
                drive_frame(8'h11, 1'b1, OS);
                drive_frame(8'h22, 1'b1, OS);
            end
            begin
                cycles(10 * OS + LAT - 1);
                check("ackc_first_data", bus.o_rxdata, 8'h11);
                ack_pulse();
            end
        join
        check("ackc_data", bus.o_rxdata, 8'h22);
        check("ackc_full", bus.o_rxfull, 1'b1);
        check("ackc_ovr", bus.o_overrun, 1'b0);
        check("ackc_ferr", bus.o_frame_err, 1'b0);

        // Reset during data bit 4 of 0xFF (holding register still full).
        fork
            drive_frame(8'hFF, 1'b1, OS);
            begin
                cycles(88);
                rst_n = 1'b0;
                #2;
                check("midrst_data", bus.o_rxdata, 8'h00);
                check("midrst_full", bus.o_rxfull, 1'b0);
                check("midrst_busy", busy, 1'b0);
                check("midrst_ferr", bus.o_frame_err, 1'b0);
                check("midrst_ovr", bus.o_overrun, 1'b0);
                cycles(3);
                rst_n = 1'b1;
            end
        join
        cycles(20);
        check("midrst_no_partial", bus.o_rxfull, 1'b0);
        check("midrst_idle", busy, 1'b0);
        fork
            drive_frame(8'h5A, 1'b1, OS);
            wait_full(LAT + 50, lat);
        join
        check("post_rst_latency", lat, LAT);
        check("post_rst_data", bus.o_rxdata, 8'h5A);
        check("post_rst_ferr", bus.o_frame_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Basic UART receiver: the receive half of the basic UART, complementing its transmitter (8 data bits, no parity, 1 stop bit, LSB first, idle-high line). It oversamples the serial RX line using a shared oversampling enable. It validates the start bit and samples each bit at its centre. Completed bytes go into a one-deep holding register with ready/acknowledge handshake, framing-error and overrun flags. It sits between the RX pin and the bus-side register block.

## Interface

- OVERSAMPLE, 16, i_rxclken ticks per bit period; even, >= 4.

- i_clk  in  1  System clock; all logic on rising edge.
- i_reset_n  in  1  System reset, asynchronous, active-low.
- i_rxclken  in  1  Oversampling enable, one-cycle pulse at OVERSAMPLE x baud rate.
- i_rx  in  1  Serial RX line; asynchronous, idle high.
- i_rxack  in  1  Consumer acknowledge; clears holding register and flags.
- o_rxdata  out  8  Received byte; valid while o_rxfull = 1.
- o_rxfull  out  1  Holding register contains an unread byte.
- o_frame_err  out  1  Byte in holding register had stop bit = 0.
- o_overrun  out  1  A byte completed while o_rxfull = 1 and was discarded.
- o_busy  out  1  Receiver FSM not in IDLE.

## Operation

- Synchronizer: i_rx passes through 2 flip-flops (reset value 1) to give rx_s; the FSM uses only rx_s.
- Tick counter: counts i_rxclken pulses, width clog2(OVERSAMPLE*10). It advances only on i_rxclken.
- **IDLE:** on a tick with rx_s = 0, clear the counter and go to START. o_busy = 0 only in IDLE.
- **START:** on the tick where the counter reaches OVERSAMPLE/2 - 1 (mid-bit), sample rx_s.
  - 1: false start, back to IDLE, nothing stored.
  - 0: clear the counter, clear bit index, go to DATA.
- **DATA:** every OVERSAMPLE ticks (counter = OVERSAMPLE - 1), shift rx_s into the shift register at bit 7, right-shifting (LSB first). After 8 bits, go to STOP.
- **STOP:** after OVERSAMPLE ticks, sample rx_s as the stop bit and commit:
  - o_rxfull = 0, or i_rxack asserted the same cycle: load o_rxdata, set o_rxfull = 1, set o_frame_err = ~stop.
  - o_rxfull = 1 and no i_rxack: discard the byte; o_rxdata and o_frame_err unchanged; set o_overrun = 1 (sticky).
  - Next state: stop = 1 goes to IDLE; stop = 0 goes to BREAK.
- **BREAK:** wait until rx_s = 1 (on any cycle), then go to IDLE. This prevents a held-low line from retriggering a start.
- i_rxack when o_rxfull = 1: clears o_rxfull, o_frame_err and o_overrun next cycle. i_rxack when o_rxfull = 0: clears o_overrun only.
- Unused state encodings: return to IDLE.

## Timing

- Reset values:
  - o_rxdata = 8'h00, o_rxfull = 0, o_frame_err = 0, o_overrun = 0, o_busy = 0.
  - FSM = IDLE, synchronizer = 1.
  - Reset mid-frame aborts it; no partial byte is committed.
- Start detection latency: 2 clocks of synchronizer plus up to 1 tick period.
- Sample points, in ticks after the detect tick:
  - Start: OVERSAMPLE/2.
  - Data bit n: OVERSAMPLE/2 + OVERSAMPLE*(n+1).
  - Stop: OVERSAMPLE/2 + 9*OVERSAMPLE.
- o_rxfull rises the clock after the stop-sample tick; flags update in the same clock.
- i_rxack and a commit in the same cycle: the new byte is loaded, o_rxfull stays 1, no overrun, and flags reflect the new byte.
- Back-to-back frames: the next start bit is detected from the first tick after the stop sample with rx_s = 0. This tolerates a half-bit stop truncation.
- i_rxclken held high continuously is legal (1 tick per clock).

## Test plan

1. Reset, i_rxclken = 1 every cycle, OVERSAMPLE = 16, send 0xA5 with stop = 1.
   - Required: o_rxfull rises 2 + 8 + 9*16 + 1 clocks after the falling edge; o_rxdata = 8'hA5, o_frame_err = 0.
   - Then i_rxack for 1 cycle: o_rxfull = 0 next cycle.
2. Low glitch of 4 ticks on idle line: o_busy pulses, returns to IDLE; o_rxfull stays 0.
3. Send 0x3C with stop = 0, line held low 40 ticks then high.
   - Required: o_rxdata = 8'h3C, o_frame_err = 1; FSM remains in BREAK until the line is high, and no second byte appears.
4. Send 0x11 then 0x22 back-to-back without ack.
   - Required: o_rxdata = 8'h11, o_overrun = 1 after the second stop.
   - Then i_rxack: o_rxfull = 0, o_overrun = 0.
5. Assert i_rxack exactly on the commit cycle of the second byte: o_rxdata = 8'h22, o_rxfull = 1, o_overrun = 0.
6. Deassert i_reset_n mid data bit 4 of 0xFF, then release.
   - Required: all outputs at reset values immediately; a subsequent 0x5A is received correctly.
